// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, single-step shift/rotate and a
// multi-cycle rotate-by-N with busy/done handshake.
module univ_shift_reg #(
    parameter int unsigned            WIDTH     = 8,
    parameter logic [WIDTH-1:0]       RESET_VAL = '0,
    localparam int unsigned           AW        = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_RORN = 3'b110;
    localparam logic [2:0] OP_ROLN = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic            dir_left;

    function automatic logic [WIDTH-1:0] rot_r(input logic [WIDTH-1:0] v);
        return {v[0], v[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] rot_l(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    assign sout_msb = q[WIDTH-1];
    assign sout_lsb = q[0];

    // Register, step counter and handshake; done defaults low so it pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= RESET_VAL;
            busy     <= 1'b0;
            done     <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            dir_left <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    unique case (op)
                        OP_HOLD: q <= q;
                        OP_LOAD: q <= d;
                        OP_SHR:  q <= {sin_msb, q[WIDTH-1:1]};
                        OP_SHL:  q <= {q[WIDTH-2:0], sin_lsb};
                        OP_ROR:  q <= rot_r(q);
                        OP_ROL:  q <= rot_l(q);
                        OP_RORN, OP_ROLN: begin
                            if (amt == AW'(0)) begin
                                done <= 1'b1;
                            end else begin
                                q <= (op == OP_ROLN) ? rot_l(q) : rot_r(q);
                                if (amt == AW'(1)) begin
                                    done <= 1'b1;
                                end else begin
                                    cnt      <= amt - AW'(1);
                                    dir_left <= (op == OP_ROLN);
                                    busy     <= 1'b1;
                                    state    <= RUN;
                                end
                            end
                        end
                        default: q <= q;
                    endcase
                end
                RUN: begin
                    // Inputs are ignored until the rotate finishes.
                    q   <= dir_left ? rot_l(q) : rot_r(q);
                    cnt <= cnt - AW'(1);
                    if (cnt == AW'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: driver pushes hand-computed expectations,
// monitor pops and compares one entry per clock.
module tb_univ_shift_reg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AW    = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2:0]       op = 3'b000;
    logic [WIDTH-1:0] d = '0;
    logic             sin_msb = 1'b0;
    logic             sin_lsb = 1'b0;
    logic [AW-1:0]    amt = '0;
    logic [WIDTH-1:0] q;
    logic             sout_msb;
    logic             sout_lsb;
    logic             busy;
    logic             done;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   step_no = 0;

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHR = 3'b010, SHL = 3'b011;
    localparam logic [2:0] ROR = 3'b100, ROL = 3'b101, RORN = 3'b110, ROLN = 3'b111;

    univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'hA5)) dut (
        .clk(clk), .rst(rst), .op(op), .d(d), .sin_msb(sin_msb), .sin_lsb(sin_lsb),
        .amt(amt), .q(q), .sout_msb(sout_msb), .sout_lsb(sout_lsb),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus and record what must be seen after the next edge.
    task automatic step(input logic r, input logic [2:0] o, input logic [7:0] dv,
                        input logic sm, input logic sl, input logic [AW-1:0] a,
                        input logic [7:0] eq, input logic eb, input logic ed);
        exp_t e;
        @(negedge clk);
        rst = r; op = o; d = dv; sin_msb = sm; sin_lsb = sl; amt = a;
        step_no++;
        e.idx = 8'(step_no); e.q = eq; e.busy = eb; e.done = ed;
        sb.push_back(e);
    endtask

    task automatic check_direct(input string name, input logic [7:0] eq,
                                input logic eb, input logic ed);
        total++;
        if ({q, busy, done} !== {eq, eb, ed}) begin
            bad++;
            $display("FAIL %s: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                     name, q, busy, done, eq, eb, ed);
        end
    endtask

    // Monitor: one expectation per clock, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if ({q, busy, done, sout_msb, sout_lsb} !==
                    {e.q, e.busy, e.done, e.q[7], e.q[0]}) begin
                    bad++;
                    $display("FAIL step%0d: got q=%h busy=%b done=%b sout=%b%b, want q=%h busy=%b done=%b sout=%b%b",
                             e.idx, q, busy, done, sout_msb, sout_lsb,
                             e.q, e.busy, e.done, e.q[7], e.q[0]);
                end
            end
        end
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #2;
        rst = 1'b1; op = LOAD; d = 8'h00;
        #1;
        check_direct("async_reset", 8'hA5, 1'b0, 1'b0);

        step(1, LOAD, 8'h00, 0, 0, 4'd0, 8'hA5, 0, 0);
        step(1, LOAD, 8'h00, 0, 0, 4'd0, 8'hA5, 0, 0);
        // Single-step operations.
        step(0, LOAD, 8'h96, 0, 0, 4'd0, 8'h96, 0, 0);
        step(0, SHR,  8'h00, 1, 0, 4'd0, 8'hCB, 0, 0);
        step(0, SHL,  8'h00, 0, 0, 4'd0, 8'h96, 0, 0);
        step(0, ROR,  8'h00, 0, 0, 4'd0, 8'h4B, 0, 0);
        step(0, ROL,  8'h00, 0, 0, 4'd0, 8'h96, 0, 0);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'h96, 0, 0);
        // RORN by 3 with LOAD attempts ignored while running.
        step(0, LOAD, 8'h81, 0, 0, 4'd0, 8'h81, 0, 0);
        step(0, RORN, 8'h00, 0, 0, 4'd3, 8'hC0, 1, 0);
        step(0, LOAD, 8'hFF, 1, 1, 4'd0, 8'h60, 1, 0);
        step(0, LOAD, 8'hFF, 1, 1, 4'd0, 8'h30, 0, 1);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'h30, 0, 0);
        // ROLN by 9 wraps past WIDTH.
        step(0, ROLN, 8'h00, 0, 0, 4'd9, 8'h60, 1, 0);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'hC0, 1, 0);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'h81, 1, 0);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'h03, 1, 0);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'h06, 1, 0);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'h0C, 1, 0);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'h18, 1, 0);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'h30, 1, 0);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'h60, 0, 1);
        // amt = 0 and amt = 1 never raise busy.
        step(0, RORN, 8'h00, 0, 0, 4'd0, 8'h60, 0, 1);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'h60, 0, 0);
        step(0, RORN, 8'h00, 0, 0, 4'd1, 8'h30, 0, 1);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'h30, 0, 0);
        // Back-to-back: ROLN issued while done is high.
        step(0, RORN, 8'h00, 0, 0, 4'd2, 8'h18, 1, 0);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'h0C, 0, 1);
        step(0, ROLN, 8'h00, 0, 0, 4'd2, 8'h18, 1, 0);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'h30, 0, 1);
        // Abort a running rotate with reset.
        step(0, RORN, 8'h00, 0, 0, 4'd4, 8'h18, 1, 0);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'h0C, 1, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_direct("abort_reset", 8'hA5, 1'b0, 1'b0);
        step(1, HOLD, 8'h00, 0, 0, 4'd0, 8'hA5, 0, 0);
        step(1, HOLD, 8'h00, 0, 0, 4'd0, 8'hA5, 0, 0);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'hA5, 0, 0);
        step(0, LOAD, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
        step(0, HOLD, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);

        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
